// File: rtl/rs_parity_accum.sv
// Parity accumulator for the matrix-parallel RS(544,522) encoder: XOR-accumulates
// one R-lane product vector per message symbol, then drains the R parity symbols serially.
module rs_parity_accum #(
  parameter int W = 10,
  parameter int R = 22,
  parameter int K = 522
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [W*R-1:0] v_i,
  input  logic           in_last_i,
  output logic           p_valid_o,
  input  logic           p_ready_i,
  output logic [W-1:0]   p_o,
  output logic           p_last_o,
  output logic           frame_err_o,
  output logic           busy_o
);

  localparam int CW = $clog2(K);
  localparam int IW = $clog2(R);

  typedef enum logic {ST_ACC, ST_DRAIN} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_err;
  logic [W-1:0]  r_par [R];

  logic w_acc;
  logic w_drain;
  logic w_cnt_last;
  logic w_idx_last;

  assign w_acc      = in_valid_i & (r_state == ST_ACC);
  assign w_drain    = p_ready_i & (r_state == ST_DRAIN);
  assign w_cnt_last = (r_cnt == CW'(K - 1));
  assign w_idx_last = (r_idx == IW'(R - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      for (int j = 0; j < R; j++) r_par[j] <= '0;
    end else begin
      r_err <= w_acc & (in_last_i != w_cnt_last);
      if (w_acc) begin
        // First symbol of a frame loads the registers, so no separate clear cycle is needed.
        for (int j = 0; j < R; j++)
          r_par[j] <= (r_cnt == '0) ? v_i[j*W +: W] : (r_par[j] ^ v_i[j*W +: W]);
        if (w_cnt_last) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= ST_DRAIN;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_drain) begin
        if (w_idx_last) begin
          r_idx   <= '0;
          r_state <= ST_ACC;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign in_ready_o  = (r_state == ST_ACC);
  assign p_valid_o   = (r_state == ST_DRAIN);
  assign p_o         = r_par[r_idx];
  assign p_last_o    = p_valid_o & w_idx_last;
  assign frame_err_o = r_err;
  assign busy_o      = p_valid_o | (r_cnt != '0);

endmodule

// File: tb/tb_rs_parity_accum.sv
// Randomized bench for rs_parity_accum against a frame-level XOR/queue reference model.
module tb_rs_parity_accum;
  localparam int W = 10;
  localparam int R = 22;
  localparam int K = 522;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [W*R-1:0] v_i = '0;
  logic           in_last_i = 1'b0;
  logic           p_valid_o;
  logic           p_ready_i = 1'b1;
  logic [W-1:0]   p_o;
  logic           p_last_o;
  logic           frame_err_o;
  logic           busy_o;

  rs_parity_accum #(.W(W), .R(R), .K(K)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .v_i(v_i), .in_last_i(in_last_i), .p_valid_o(p_valid_o), .p_ready_i(p_ready_i),
    .p_o(p_o), .p_last_o(p_last_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the XOR of its K accepted vectors; the drain is a queue of R symbols.
  logic [W-1:0] m_acc [R];
  logic [W-1:0] m_q [$];
  int           m_cnt = 0;
  bit           m_err = 1'b0;
  bit           armed = 1'b0;

  // Observation state recorded at the clock edge
  logic [W-1:0] got [$];
  int           cyc = 0;
  int           last_cyc = 0;
  int           start_cyc = 0;
  int           err_seen = 0;
  bit           stall_prev = 1'b0;
  logic [W:0]   held_prev = '0;

  always @(posedge clk) begin
    cyc++;
    if (armed && stall_prev && p_valid_o) chk("hold_p", {21'd0, p_last_o, p_o}, {21'd0, held_prev});
    stall_prev = p_valid_o && !p_ready_i && !rst_i;
    held_prev  = {p_last_o, p_o};
    if (p_valid_o && p_ready_i && !rst_i) begin
      got.push_back(p_o);
      if (p_last_o) last_cyc = cyc;
    end
    if (in_valid_i && in_ready_o && !rst_i && m_cnt == 0) start_cyc = cyc;

    if (rst_i) begin
      m_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      for (int j = 0; j < R; j++) m_acc[j] = '0;
      armed = 1'b1;
    end else if (armed) begin
      bit acc_b;
      acc_b = in_valid_i && (m_q.size() == 0);
      m_err = acc_b && (in_last_i != (m_cnt == K - 1));
      if (m_q.size() != 0 && p_ready_i) void'(m_q.pop_front());
      if (acc_b) begin
        if (m_cnt == 0) for (int j = 0; j < R; j++) m_acc[j] = '0;
        for (int j = 0; j < R; j++) m_acc[j] = m_acc[j] ^ v_i[j*W +: W];
        m_cnt++;
        if (m_cnt == K) begin
          for (int j = 0; j < R; j++) m_q.push_back(m_acc[j]);
          m_cnt = 0;
        end
      end
    end
  end

  // Single compare process: every cycle after the first reset
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", {31'd0, in_ready_o}, {31'd0, m_q.size() == 0});
      chk("p_valid", {31'd0, p_valid_o}, {31'd0, m_q.size() != 0});
      chk("frame_err", {31'd0, frame_err_o}, {31'd0, m_err});
      chk("busy", {31'd0, busy_o}, {31'd0, (m_q.size() != 0) || (m_cnt != 0)});
      if (m_q.size() != 0) begin
        chk("p_o", {22'd0, p_o}, {22'd0, m_q[0]});
        chk("p_last", {31'd0, p_last_o}, {31'd0, m_q.size() == 1});
      end
      if (frame_err_o) err_seen++;
    end
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random
  int rdy_mode = 0;
  int rdy_ph = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0: p_ready_i = 1'b1;
      1: p_ready_i = (rdy_ph % 3 == 0);
      default: p_ready_i = 1'($urandom_range(0, 1));
    endcase
    rdy_ph++;
  end

  function automatic logic [W*R-1:0] rand_vec();
    logic [W*R-1:0] v;
    for (int j = 0; j < R; j++) v[j*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic push_vec(input logic [W*R-1:0] v, input logic last, input bit gap);
    int n;
    if (gap && $urandom_range(0, 3) == 0) begin
      in_valid_i = 1'b0;
      v_i = rand_vec();
      @(negedge clk);
    end
    in_valid_i = 1'b1;
    v_i = v;
    in_last_i = last;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      $display("FAIL accept_timeout actual=stalled required=accept");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "accept timeout");
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  // mode: 0 random, 1 one-hot lanes on beat 0, 2 two 3FF beats, 3 three 3FF beats
  task automatic push_frame(input int mode, input bit gap, input int extra_last, input bit drop_last);
    logic [W*R-1:0] v;
    logic [W-1:0]   s;
    logic           lst;
    for (int b = 0; b < K; b++) begin
      v = '0;
      case (mode)
        0: v = rand_vec();
        1: if (b == 0) for (int j = 0; j < R; j++) begin
             s = W'(1) << (j % 10);
             v[j*W +: W] = s;
           end
        2: if (b < 2) v = {R{10'h3FF}};
        default: if (b < 3) v = {R{10'h3FF}};
      endcase
      lst = (b == K - 1) && !drop_last;
      if (b == extra_last) lst = 1'b1;
      push_vec(v, lst, gap);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((p_valid_o || m_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'd0, p_valid_o}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] e;
    // T1 reset with random inputs
    rdy_mode = 2;
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      in_last_i  = 1'($urandom_range(0, 1));
      v_i = rand_vec();
      @(negedge clk);
    end
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_p_valid", {31'd0, p_valid_o}, 32'd0);
    chk("rst_p_o", {22'd0, p_o}, 32'd0);
    chk("rst_p_last", {31'd0, p_last_o}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);

    // T2 single frame with one-hot lanes
    rdy_mode = 0;
    got.delete();
    err_seen = 0;
    push_frame(1, 1'b1, -1, 1'b0);
    wait_drain();
    chk("t2_beats", got.size(), R);
    for (int k = 0; k < R && k < got.size(); k++) begin
      e = W'(1) << (k % 10);
      chk("t2_sym", {22'd0, got[k]}, {22'd0, e});
    end
    chk("t2_err", err_seen, 0);

    // T3 XOR cancel, then odd count of 3FF
    got.delete();
    push_frame(2, 1'b0, -1, 1'b0);
    wait_drain();
    chk("t3_beats", got.size(), R);
    for (int k = 0; k < got.size(); k++) chk("t3_zero", {22'd0, got[k]}, 32'd0);
    got.delete();
    push_frame(3, 1'b1, -1, 1'b0);
    wait_drain();
    for (int k = 0; k < got.size(); k++) chk("t3_3ff", {22'd0, got[k]}, 32'h3FF);

    // T4 backpressure on the drain
    rdy_mode = 1;
    got.delete();
    push_frame(0, 1'b1, -1, 1'b0);
    wait_drain();
    chk("t4_beats", got.size(), R);

    // T5 back-to-back frames, valid held high
    rdy_mode = 0;
    push_frame(0, 1'b0, -1, 1'b0);
    push_frame(0, 1'b0, -1, 1'b0);
    chk("t5_gap", start_cyc - last_cyc, 1);
    wait_drain();

    // T6 framing faults, then reset mid-drain
    err_seen = 0;
    push_frame(0, 1'b1, 100, 1'b1);
    wait_drain();
    chk("t6_err_pulses", err_seen, 2);
    got.delete();
    push_frame(0, 1'b0, -1, 1'b0);
    begin
      int n;
      n = 0;
      while (got.size() < 5 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_idx5", got.size(), 5);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("t6_rst_valid", {31'd0, p_valid_o}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    rdy_mode = 2;
    push_frame(0, 1'b1, -1, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
